// File: rtl/image_stream_framer_pkg.sv
// Shared constants, colour-field slices and FSM encoding for the image stream framer.
package image_stream_pkg;

    localparam int PIXEL_W = 24;
    localparam int R_MSB   = 23;
    localparam int G_MSB   = 15;
    localparam int B_MSB   = 7;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // R+G+B of one packed pixel, widened so the running sum can wrap at 16 bits.
    function automatic logic [15:0] pixel_sum(input logic [PIXEL_W-1:0] p);
        return 16'(p[R_MSB -: 8]) + 16'(p[G_MSB -: 8]) + 16'(p[B_MSB -: 8]);
    endfunction

endpackage

// File: rtl/image_stream_framer_fifo.sv
// Synchronous FIFO with registered pointers/level; the head word is readable without a pop.
module stream_sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign dout  = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    always_comb begin
        do_push  = push & (~full | pop) & ~flush;
        do_pop   = pop & ~empty & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      level_d = level_q + 1'b1;
            else if (!do_push && do_pop) level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/image_stream_framer.sv
// Frames a backpressure-free pixel stream into ready/valid video with SOF/EOL markers.
// Optional running R+G+B frame checksum output when FRAMER_CHECKSUM_EN is defined.
module image_stream_framer #(
    parameter int IMAGE_WIDTH  = 512,
    parameter int IMAGE_HEIGHT = 512,
    parameter int FIFO_DEPTH   = 16,
    parameter int PIXEL_W      = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_start,
    input  logic [PIXEL_W-1:0]            in_pixel,
    input  logic                          in_valid,
    output logic [PIXEL_W-1:0]            m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_sof,
    output logic                          m_eol,
    output logic                          frame_done,
    output logic                          overflow,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef FRAMER_CHECKSUM_EN
    ,
    output logic [15:0]                   frame_checksum
`endif
);

    import image_stream_pkg::*;

    localparam int XW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int YW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          overflow_q, overflow_d;
    logic          done_q, done_d;
    logic          fifo_full, fifo_empty;
    logic          hs, last_x, last_y, push_req, push, drop;

    stream_sync_fifo #(
        .WIDTH (PIXEL_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (hs),
        .flush (frame_start),
        .din   (in_pixel),
        .dout  (m_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign busy       = (state_q == ST_ACTIVE);
    assign m_valid    = busy & ~fifo_empty;
    assign m_sof      = m_valid & (x_q == '0) & (y_q == '0);
    assign m_eol      = m_valid & last_x;
    assign frame_done = done_q;
    assign overflow   = overflow_q;

    // frame_start dominates everything: the FIFO is flushed and a coincident pixel is lost.
    always_comb begin
        hs         = m_valid & m_ready;
        last_x     = (x_q == XW'(IMAGE_WIDTH - 1));
        last_y     = (y_q == YW'(IMAGE_HEIGHT - 1));
        push_req   = busy & in_valid & ~frame_start;
        push       = push_req & (~fifo_full | hs);
        drop       = push_req & fifo_full & ~hs;
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        overflow_d = overflow_q | drop;
        done_d     = 1'b0;
        if (frame_start) begin
            state_d    = ST_ACTIVE;
            x_d        = '0;
            y_d        = '0;
            overflow_d = 1'b0;
        end else if (hs) begin
            if (last_x) begin
                x_d = '0;
                if (last_y) begin
                    y_d     = '0;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

`ifdef FRAMER_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;
    logic [15:0] checksum_q, checksum_d;

    assign frame_checksum = checksum_q;

    // The checksum register captures on the same edge that raises frame_done.
    always_comb begin
        sum_d      = sum_q;
        checksum_d = checksum_q;
        if (frame_start) begin
            sum_d = '0;
        end else if (hs) begin
            sum_d = sum_q + pixel_sum(m_data);
            if (last_x && last_y) checksum_d = sum_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q      <= '0;
            checksum_q <= '0;
        end else begin
            sum_q      <= sum_d;
            checksum_q <= checksum_d;
        end
    end
`endif

endmodule

// File: tb/tb_image_stream_framer.sv
// Bench for image_stream_framer: table vectors, corner-case sequences and a queue-based model.
module tb_image_stream_framer;

    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [23:0] in_pixel;
    logic        in_valid;
    logic [23:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_sof;
    logic        m_eol;
    logic        frame_done;
    logic        overflow;
    logic        busy;
    logic [2:0]  fifo_level;
`ifdef FRAMER_CHECKSUM_EN
    logic [15:0] frame_checksum;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    image_stream_framer #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .FIFO_DEPTH   (D),
        .PIXEL_W      (24)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .in_pixel    (in_pixel),
        .in_valid    (in_valid),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_sof       (m_sof),
        .m_eol       (m_eol),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .busy        (busy),
        .fifo_level  (fifo_level)
`ifdef FRAMER_CHECKSUM_EN
        ,
        .frame_checksum (frame_checksum)
`endif
    );

    // Reference model: pixel queue plus linear pixel index within the frame.
    logic [23:0] mq[$];
    bit          m_act;
    int          m_idx;
    bit          m_ovf;
    bit          m_done;
    logic [15:0] m_sum;
    logic [15:0] m_cks;

    function automatic logic [15:0] rgb(input logic [23:0] p);
        return 16'(p[23:16]) + 16'(p[15:8]) + 16'(p[7:0]);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_act = 0; m_idx = 0; m_ovf = 0; m_done = 0; m_sum = '0; m_cks = '0;
    endtask

    task automatic model_edge(input bit fs, input bit iv, input logic [23:0] px, input bit rdy);
        bit act0;
        int sz0;
        bit hs;
        act0   = m_act;
        sz0    = mq.size();
        hs     = act0 && (sz0 > 0) && rdy;
        m_done = 0;
        if (fs) begin
            mq.delete();
            m_act = 1; m_idx = 0; m_ovf = 0; m_sum = '0;
            return;
        end
        if (hs) begin
            m_sum = m_sum + rgb(mq[0]);
            void'(mq.pop_front());
            m_idx++;
            if (m_idx == W * H) begin
                m_idx  = 0;
                m_act  = 0;
                m_done = 1;
                m_cks  = m_sum;
            end
        end
        if (act0 && iv) begin
            if (sz0 < D || hs) mq.push_back(px);
            else m_ovf = 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        bit ev;
        ev = m_act && (mq.size() > 0);
        chk({tag, "_valid"}, 32'(m_valid), 32'(ev));
        if (ev) chk({tag, "_data"}, 32'(m_data), 32'(mq[0]));
        chk({tag, "_sof"}, 32'(m_sof), 32'(ev && m_idx == 0));
        chk({tag, "_eol"}, 32'(m_eol), 32'(ev && (m_idx % W) == W - 1));
        chk({tag, "_done"}, 32'(frame_done), 32'(m_done));
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, "_busy"}, 32'(busy), 32'(m_act));
        chk({tag, "_level"}, 32'(fifo_level), 32'(mq.size()));
`ifdef FRAMER_CHECKSUM_EN
        chk({tag, "_cks"}, 32'(frame_checksum), 32'(m_cks));
`endif
    endtask

    task automatic cycle(input bit fs, input bit iv, input logic [23:0] px, input bit rdy);
        frame_start = fs;
        in_valid    = iv;
        in_pixel    = px;
        m_ready     = rdy;
        @(posedge clk);
        model_edge(fs, iv, px, rdy);
        #1;
    endtask

    typedef struct {
        bit          fs;
        bit          iv;
        logic [23:0] px;
        bit          rdy;
        bit          e_valid;
        logic [23:0] e_data;
        bit          e_sof;
        bit          e_eol;
        bit          e_done;
        bit          e_busy;
        logic [2:0]  e_level;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 24'h0, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0};
        tbl[1]  = '{1'b0, 1'b1, 24'h1, 1'b1, 1'b1, 24'h1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1};
        tbl[2]  = '{1'b0, 1'b1, 24'h2, 1'b1, 1'b1, 24'h2, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
        tbl[3]  = '{1'b0, 1'b1, 24'h3, 1'b1, 1'b1, 24'h3, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
        tbl[4]  = '{1'b0, 1'b1, 24'h4, 1'b1, 1'b1, 24'h4, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1};
        tbl[5]  = '{1'b0, 1'b1, 24'h5, 1'b1, 1'b1, 24'h5, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
        tbl[6]  = '{1'b0, 1'b1, 24'h6, 1'b1, 1'b1, 24'h6, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
        tbl[7]  = '{1'b0, 1'b1, 24'h7, 1'b1, 1'b1, 24'h7, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
        tbl[8]  = '{1'b0, 1'b1, 24'h8, 1'b1, 1'b1, 24'h8, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1};
        tbl[9]  = '{1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
        tbl[10] = '{1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};

        rst = 1'b1; frame_start = 0; in_valid = 0; in_pixel = '0; m_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Reset in the middle of a frame with three pixels buffered.
        cycle(1, 0, 24'h0, 0);
        for (int k = 0; k < 3; k++) cycle(0, 1, 24'hA1 + 24'(k), 0);
        chk("rstmid_pre_level", 32'(fifo_level), 32'd3);
        frame_start = 0; in_valid = 0;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_all("rstmid");
        chk("rstmid_level0", 32'(fifo_level), 32'd0);
        chk("rstmid_busy0", 32'(busy), 32'd0);
        rst = 1'b0;

        // Full 8-pixel frame with m_ready held high.
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].fs, tbl[i].iv, tbl[i].px, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), 32'(m_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) chk($sformatf("tbl%0d_data", i), 32'(m_data), 32'(tbl[i].e_data));
            chk($sformatf("tbl%0d_sof", i), 32'(m_sof), 32'(tbl[i].e_sof));
            chk($sformatf("tbl%0d_eol", i), 32'(m_eol), 32'(tbl[i].e_eol));
            chk($sformatf("tbl%0d_done", i), 32'(frame_done), 32'(tbl[i].e_done));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_level", i), 32'(fifo_level), 32'(tbl[i].e_level));
        end

        // Overflow: six pushes with m_ready low.
        cycle(1, 0, 24'h0, 0);
        check_all("ovf_fs");
        for (int k = 1; k <= 6; k++) begin
            cycle(0, 1, 24'(k), 0);
            check_all("ovf_push");
            chk("ovf_hold_data", 32'(m_data), 32'h1);
        end
        chk("ovf_level_sat", 32'(fifo_level), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        for (int k = 0; k < 5; k++) begin
            cycle(0, 0, 24'h0, 1);
            check_all("ovf_drain");
        end
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Full FIFO with simultaneous push and pop.
        cycle(1, 0, 24'h0, 0);
        for (int k = 0; k < 4; k++) cycle(0, 1, 24'h11 + 24'(k), 0);
        chk("pp_full_level", 32'(fifo_level), 32'd4);
        cycle(0, 1, 24'h15, 1);
        check_all("pp");
        chk("pp_level", 32'(fifo_level), 32'd4);
        chk("pp_ovf", 32'(overflow), 32'd0);
        chk("pp_head", 32'(m_data), 32'h12);

        // Abort after five handshakes; restart must carry SOF and no frame_done.
        cycle(1, 0, 24'h0, 0);
        for (int k = 1; k <= 6; k++) begin
            cycle(0, 1, 24'(k), 1);
            check_all("abort_run");
        end
        cycle(1, 0, 24'h0, 1);
        check_all("abort_fs");
        chk("abort_level", 32'(fifo_level), 32'd0);
        chk("abort_nodone", 32'(frame_done), 32'd0);
        cycle(0, 1, 24'h0A, 1);
        check_all("abort_next");
        chk("abort_sof", 32'(m_sof), 32'd1);
        chk("abort_data", 32'(m_data), 32'h0A);
        cycle(0, 0, 24'h0, 0);
        chk("abort_nodone2", 32'(frame_done), 32'd0);

`ifdef FRAMER_CHECKSUM_EN
        cycle(1, 0, 24'h0, 1);
        for (int k = 0; k < 8; k++) cycle(0, 1, 24'h010203, 1);
        cycle(0, 0, 24'h0, 1);
        check_all("cks");
        chk("cks_done", 32'(frame_done), 32'd1);
        chk("cks_value", 32'(frame_checksum), 32'h0030);
`endif

        // Randomised traffic against the model.
        cycle(1, 0, 24'h0, 1);
        check_all("rnd_fs");
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(149) == 0), ($urandom_range(9) < 7),
                  24'($urandom()), ($urandom_range(9) < 6));
            check_all("rnd");
            if (!m_act && ($urandom_range(3) == 0)) begin
                cycle(1, ($urandom_range(1) == 1), 24'($urandom()), 0);
                check_all("rnd_rearm");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
